// File: rtl/gc_dram_pkg.sv
// ============================================================================
// Module : gc_dram_pkg
// Brief  : Shared defaults and row-state type for the gain-cell DRAM array.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package gc_dram_pkg;

   localparam int DEF_DATA_W    = 64;
   localparam int DEF_DEPTH     = 128;
   localparam int DEF_RETENTION = 5000;
   localparam int DEF_CNT_W     = $clog2(DEF_RETENTION + 1);

   typedef struct packed {
      logic                 live;
      logic [DEF_CNT_W-1:0] count;
   } row_state_t;

endpackage

`default_nettype wire

// File: rtl/gc_retention_cell.sv
// ============================================================================
// Module : gc_retention_cell
// Brief  : Per-row retention counter; live clears when the count reaches zero.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module gc_retention_cell
   import gc_dram_pkg::*;
#(
   parameter int RETENTION = DEF_RETENTION,
   parameter int CNT_W     = $clog2(RETENTION + 1)
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             enable,
   output logic             live,
   output logic [CNT_W-1:0] count
);

   logic             live_q;
   logic [CNT_W-1:0] count_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         live_q  <= 1'b0;
         count_q <= '0;
      end else if (load) begin
         live_q  <= 1'b1;
         count_q <= CNT_W'(RETENTION);
      end else if (enable && live_q) begin
         count_q <= count_q - CNT_W'(1);
         if (count_q == CNT_W'(1)) live_q <= 1'b0;
      end
   end

   assign live  = live_q;
   assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/gc_dram_array.sv
// ============================================================================
// Module : gc_dram_array
// Brief  : Gain-cell DRAM array model with per-row retention, refresh and
//          registered read port.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module gc_dram_array
   import gc_dram_pkg::*;
#(
   parameter int DATA_W       = DEF_DATA_W,
   parameter int DEPTH        = DEF_DEPTH,
   parameter int RETENTION    = DEF_RETENTION,
   parameter int READ_RESTORE = 0,
   localparam int ADDR_W      = $clog2(DEPTH),
   localparam int CNT_W       = $clog2(RETENTION + 1)
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   input  logic              ref_en,
   input  logic [ADDR_W-1:0] ref_addr,
   output logic [DATA_W-1:0] rdata,
   output logic              rvalid,
   output logic              rd_err,
   output logic              ref_err,
   output logic [ADDR_W:0]   live_cnt
);

   logic [DEPTH-1:0]  live;
   logic [CNT_W-1:0]  count [DEPTH];
   logic [DEPTH-1:0]  load;
   logic [DEPTH-1:0]  live_nxt;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              wr_ok, rd_ok, ref_hit, ref_ok;
   logic [DATA_W-1:0] rdata_d;
   logic [ADDR_W:0]   live_cnt_d;

   logic [DATA_W-1:0] rdata_q;
   logic              rvalid_q, rd_err_q, ref_err_q;
   logic [ADDR_W:0]   live_cnt_q;

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return ({1'b0, a} < (ADDR_W+1)'(DEPTH));
   endfunction

   assign wr_ok   = we && in_range(waddr);
   // A row on its final count still holds data for refresh but not for reads.
   assign rd_ok   = re && in_range(raddr) && !(we && (waddr == raddr)) &&
                    live[raddr] && (count[raddr] > CNT_W'(1));
   assign ref_hit = ref_en && in_range(ref_addr) && !(wr_ok && (waddr == ref_addr));
   assign ref_ok  = ref_hit && live[ref_addr];
   assign rdata_d = rd_ok ? mem[raddr] : '0;

   always_comb begin
      load       = '0;
      live_nxt   = '0;
      live_cnt_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
         load[i] = (wr_ok  && (waddr    == ADDR_W'(i))) ||
                   (ref_ok && (ref_addr == ADDR_W'(i))) ||
                   ((READ_RESTORE != 0) && rd_ok && (raddr == ADDR_W'(i)));
         live_nxt[i] = load[i] || (live[i] && (count[i] != CNT_W'(1)));
         live_cnt_d  = live_cnt_d + (ADDR_W+1)'(live_nxt[i]);
      end
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_row
      gc_retention_cell #(
         .RETENTION (RETENTION),
         .CNT_W     (CNT_W)
      ) u_cell (
         .clk    (clk),
         .rst    (rst),
         .load   (load[i]),
         .enable (1'b1),
         .live   (live[i]),
         .count  (count[i])
      );
   end

   always_ff @(posedge clk) begin
      if (wr_ok) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_q    <= '0;
         rvalid_q   <= 1'b0;
         rd_err_q   <= 1'b0;
         ref_err_q  <= 1'b0;
         live_cnt_q <= '0;
      end else begin
         rvalid_q   <= re;
         rd_err_q   <= re && !rd_ok;
         if (re) rdata_q <= rdata_d;
         ref_err_q  <= ref_hit && !live[ref_addr];
         live_cnt_q <= live_cnt_d;
      end
   end

   assign rdata    = rdata_q;
   assign rvalid   = rvalid_q;
   assign rd_err   = rd_err_q;
   assign ref_err  = ref_err_q;
   assign live_cnt = live_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_gc_dram_array.sv
// ============================================================================
// Module : tb_gc_dram_array
// Brief  : Directed self-checking bench for gc_dram_array (16x8, retention 8).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_gc_dram_array;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        we = 1'b0, re = 1'b0, ref_en = 1'b0;
   logic [2:0]  waddr = '0, raddr = '0, ref_addr = '0;
   logic [15:0] wdata = '0;

   logic [15:0] rdata0, rdata1;
   logic        rvalid0, rvalid1, rd_err0, rd_err1, ref_err0, ref_err1;
   logic [3:0]  live_cnt0, live_cnt1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   gc_dram_array #(.DATA_W(16), .DEPTH(8), .RETENTION(8), .READ_RESTORE(0)) u_dut0 (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
      .re(re), .raddr(raddr), .ref_en(ref_en), .ref_addr(ref_addr),
      .rdata(rdata0), .rvalid(rvalid0), .rd_err(rd_err0), .ref_err(ref_err0),
      .live_cnt(live_cnt0)
   );

   gc_dram_array #(.DATA_W(16), .DEPTH(8), .RETENTION(8), .READ_RESTORE(1)) u_dut1 (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
      .re(re), .raddr(raddr), .ref_en(ref_en), .ref_addr(ref_addr),
      .rdata(rdata1), .rvalid(rvalid1), .rd_err(rd_err1), .ref_err(ref_err1),
      .live_cnt(live_cnt1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we = 1'b0; re = 1'b0; ref_en = 1'b0;
   endtask

   task automatic idle_n(input int n);
      idle();
      repeat (n) tick();
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #3;
      if (rdata0 !== 16'h0) begin errors++; $display("FAIL rst_rdata: got %h expected %h", rdata0, 16'h0); end checks++;
      if (rvalid0 !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b expected 0", rvalid0); end checks++;
      if (rd_err0 !== 1'b0) begin errors++; $display("FAIL rst_rd_err: got %b expected 0", rd_err0); end checks++;
      if (ref_err0 !== 1'b0) begin errors++; $display("FAIL rst_ref_err: got %b expected 0", ref_err0); end checks++;
      if (live_cnt0 !== 4'd0) begin errors++; $display("FAIL rst_live_cnt: got %0d expected 0", live_cnt0); end checks++;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_expiry();
      do_reset();
      we = 1'b1; waddr = 3'd3; wdata = 16'hBEEF;
      tick();                                   // edge 0
      idle();
      if (live_cnt0 !== 4'd1) begin errors++; $display("FAIL exp_live_after_wr: got %0d expected 1", live_cnt0); end checks++;
      idle_n(6);                                // edges 1..6
      re = 1'b1; raddr = 3'd3;
      tick();                                   // edge 7
      if (rvalid0 !== 1'b1) begin errors++; $display("FAIL exp_rvalid7: got %b expected 1", rvalid0); end checks++;
      if (rdata0 !== 16'hBEEF) begin errors++; $display("FAIL exp_rdata7: got %h expected %h", rdata0, 16'hBEEF); end checks++;
      if (rd_err0 !== 1'b0) begin errors++; $display("FAIL exp_rd_err7: got %b expected 0", rd_err0); end checks++;
      if (live_cnt0 !== 4'd1) begin errors++; $display("FAIL exp_live7: got %0d expected 1", live_cnt0); end checks++;
      tick();                                   // edge 8
      if (rvalid0 !== 1'b1) begin errors++; $display("FAIL exp_rvalid8: got %b expected 1", rvalid0); end checks++;
      if (rdata0 !== 16'h0) begin errors++; $display("FAIL exp_rdata8: got %h expected %h", rdata0, 16'h0); end checks++;
      if (rd_err0 !== 1'b1) begin errors++; $display("FAIL exp_rd_err8: got %b expected 1", rd_err0); end checks++;
      if (live_cnt0 !== 4'd0) begin errors++; $display("FAIL exp_live8: got %0d expected 0", live_cnt0); end checks++;
      idle_n(1);
      if (rvalid0 !== 1'b0) begin errors++; $display("FAIL exp_idle_rvalid: got %b expected 0", rvalid0); end checks++;
      if (rd_err0 !== 1'b0) begin errors++; $display("FAIL exp_idle_rd_err: got %b expected 0", rd_err0); end checks++;
   endtask

   task automatic test_refresh();
      do_reset();
      we = 1'b1; waddr = 3'd5; wdata = 16'h5A5A;
      tick();                                   // edge 0
      idle_n(5);                                // edges 1..5
      ref_en = 1'b1; ref_addr = 3'd5;
      tick();                                   // edge 6
      if (ref_err0 !== 1'b0) begin errors++; $display("FAIL ref_err6: got %b expected 0", ref_err0); end checks++;
      idle_n(6);                                // edges 7..12
      re = 1'b1; raddr = 3'd5;
      tick();                                   // edge 13
      if (rdata0 !== 16'h5A5A) begin errors++; $display("FAIL ref_rdata13: got %h expected %h", rdata0, 16'h5A5A); end checks++;
      if (rd_err0 !== 1'b0) begin errors++; $display("FAIL ref_rd_err13: got %b expected 0", rd_err0); end checks++;
      tick();                                   // edge 14
      if (rd_err0 !== 1'b1) begin errors++; $display("FAIL ref_rd_err14: got %b expected 1", rd_err0); end checks++;
      if (rdata0 !== 16'h0) begin errors++; $display("FAIL ref_rdata14: got %h expected %h", rdata0, 16'h0); end checks++;
      idle();
   endtask

   task automatic test_refresh_boundary();
      do_reset();
      we = 1'b1; waddr = 3'd7; wdata = 16'h7777;
      tick();                                   // edge 0
      waddr = 3'd4; wdata = 16'h4444;
      tick();                                   // edge 1
      idle_n(6);                                // edges 2..7
      ref_en = 1'b1; ref_addr = 3'd7;
      tick();                                   // edge 8: row 7 on its last count
      idle();
      if (ref_err0 !== 1'b0) begin errors++; $display("FAIL bnd_ref_err8: got %b expected 0", ref_err0); end checks++;
      if (live_cnt0 !== 4'd2) begin errors++; $display("FAIL bnd_live8: got %0d expected 2", live_cnt0); end checks++;
      tick();                                   // edge 9: row 4 expires
      if (live_cnt0 !== 4'd1) begin errors++; $display("FAIL bnd_live9: got %0d expected 1", live_cnt0); end checks++;
      ref_en = 1'b1; ref_addr = 3'd4;
      tick();                                   // edge 10
      if (ref_err0 !== 1'b1) begin errors++; $display("FAIL bnd_ref_err10: got %b expected 1", ref_err0); end checks++;
      if (live_cnt0 !== 4'd1) begin errors++; $display("FAIL bnd_live10: got %0d expected 1", live_cnt0); end checks++;
      idle_n(1);                                // edge 11
      if (ref_err0 !== 1'b0) begin errors++; $display("FAIL bnd_ref_err11: got %b expected 0", ref_err0); end checks++;
      re = 1'b1; raddr = 3'd7;
      tick();                                   // edge 12
      idle();
      if (rdata0 !== 16'h7777) begin errors++; $display("FAIL bnd_rdata12: got %h expected %h", rdata0, 16'h7777); end checks++;
      if (rd_err0 !== 1'b0) begin errors++; $display("FAIL bnd_rd_err12: got %b expected 0", rd_err0); end checks++;
   endtask

   task automatic test_collision();
      do_reset();
      we = 1'b1; re = 1'b1; waddr = 3'd2; raddr = 3'd2; wdata = 16'h1234;
      tick();
      we = 1'b0;
      if (rvalid0 !== 1'b1) begin errors++; $display("FAIL col_rvalid: got %b expected 1", rvalid0); end checks++;
      if (rd_err0 !== 1'b1) begin errors++; $display("FAIL col_rd_err: got %b expected 1", rd_err0); end checks++;
      if (rdata0 !== 16'h0) begin errors++; $display("FAIL col_rdata: got %h expected %h", rdata0, 16'h0); end checks++;
      if (live_cnt0 !== 4'd1) begin errors++; $display("FAIL col_live: got %0d expected 1", live_cnt0); end checks++;
      tick();
      if (rdata0 !== 16'h1234) begin errors++; $display("FAIL col_reread: got %h expected %h", rdata0, 16'h1234); end checks++;
      if (rd_err0 !== 1'b0) begin errors++; $display("FAIL col_reread_err: got %b expected 0", rd_err0); end checks++;
      idle_n(1);
      if (rdata0 !== 16'h1234) begin errors++; $display("FAIL col_hold: got %h expected %h", rdata0, 16'h1234); end checks++;
      if (rvalid0 !== 1'b0) begin errors++; $display("FAIL col_hold_rvalid: got %b expected 0", rvalid0); end checks++;
   endtask

   task automatic test_refresh_unwritten();
      do_reset();
      ref_en = 1'b1; ref_addr = 3'd6;
      tick();
      idle();
      if (ref_err0 !== 1'b1) begin errors++; $display("FAIL unw_ref_err: got %b expected 1", ref_err0); end checks++;
      if (live_cnt0 !== 4'd0) begin errors++; $display("FAIL unw_live: got %0d expected 0", live_cnt0); end checks++;
      tick();
      if (ref_err0 !== 1'b0) begin errors++; $display("FAIL unw_pulse: got %b expected 0", ref_err0); end checks++;
      we = 1'b1; waddr = 3'd6; wdata = 16'h6666; ref_en = 1'b1; ref_addr = 3'd6;
      tick();
      idle();
      if (ref_err0 !== 1'b0) begin errors++; $display("FAIL wr_ref_err: got %b expected 0", ref_err0); end checks++;
      if (live_cnt0 !== 4'd1) begin errors++; $display("FAIL wr_ref_live: got %0d expected 1", live_cnt0); end checks++;
   endtask

   task automatic test_reset_midop();
      do_reset();
      for (int i = 0; i < 8; i++) begin
         we = 1'b1; waddr = 3'(i); wdata = 16'hA000 + 16'(i);
         tick();                                // edge i
      end
      idle_n(2);                                // edges 8, 9
      re = 1'b1; raddr = 3'd7;
      tick();                                   // edge 10
      idle();
      if (rdata0 !== 16'hA007) begin errors++; $display("FAIL mid_rdata: got %h expected %h", rdata0, 16'hA007); end checks++;
      if (live_cnt0 !== 4'd5) begin errors++; $display("FAIL mid_live: got %0d expected 5", live_cnt0); end checks++;
      #2 rst = 1'b1;
      #1;
      if (rdata0 !== 16'h0) begin errors++; $display("FAIL mid_rst_rdata: got %h expected %h", rdata0, 16'h0); end checks++;
      if (rvalid0 !== 1'b0) begin errors++; $display("FAIL mid_rst_rvalid: got %b expected 0", rvalid0); end checks++;
      if (rd_err0 !== 1'b0) begin errors++; $display("FAIL mid_rst_rd_err: got %b expected 0", rd_err0); end checks++;
      if (ref_err0 !== 1'b0) begin errors++; $display("FAIL mid_rst_ref_err: got %b expected 0", ref_err0); end checks++;
      if (live_cnt0 !== 4'd0) begin errors++; $display("FAIL mid_rst_live: got %0d expected 0", live_cnt0); end checks++;
      tick();
      rst = 1'b0;
      re = 1'b1; raddr = 3'd0;
      tick();
      if (rvalid0 !== 1'b1) begin errors++; $display("FAIL post_rst_rvalid: got %b expected 1", rvalid0); end checks++;
      if (rd_err0 !== 1'b1) begin errors++; $display("FAIL post_rst_rd_err0: got %b expected 1", rd_err0); end checks++;
      raddr = 3'd7;
      tick();
      idle();
      if (rd_err0 !== 1'b1) begin errors++; $display("FAIL post_rst_rd_err7: got %b expected 1", rd_err0); end checks++;
      if (rdata0 !== 16'h0) begin errors++; $display("FAIL post_rst_rdata7: got %h expected %h", rdata0, 16'h0); end checks++;
   endtask

   task automatic test_read_restore();
      do_reset();
      we = 1'b1; waddr = 3'd1; wdata = 16'h1111;
      tick();                                   // edge 0
      idle_n(4);                                // edges 1..4
      re = 1'b1; raddr = 3'd1;
      tick();                                   // edge 5
      if (rdata1 !== 16'h1111) begin errors++; $display("FAIL rr_rdata5: got %h expected %h", rdata1, 16'h1111); end checks++;
      if (rd_err1 !== 1'b0) begin errors++; $display("FAIL rr_rd_err5: got %b expected 0", rd_err1); end checks++;
      if (rd_err0 !== 1'b0) begin errors++; $display("FAIL nr_rd_err5: got %b expected 0", rd_err0); end checks++;
      idle_n(4);                                // edges 6..9
      re = 1'b1;
      tick();                                   // edge 10
      if (rdata1 !== 16'h1111) begin errors++; $display("FAIL rr_rdata10: got %h expected %h", rdata1, 16'h1111); end checks++;
      if (rd_err1 !== 1'b0) begin errors++; $display("FAIL rr_rd_err10: got %b expected 0", rd_err1); end checks++;
      if (rd_err0 !== 1'b1) begin errors++; $display("FAIL nr_rd_err10: got %b expected 1", rd_err0); end checks++;
      idle_n(7);                                // edges 11..17
      if (live_cnt1 !== 4'd1) begin errors++; $display("FAIL rr_live17: got %0d expected 1", live_cnt1); end checks++;
      if (live_cnt0 !== 4'd0) begin errors++; $display("FAIL nr_live17: got %0d expected 0", live_cnt0); end checks++;
      re = 1'b1;
      tick();                                   // edge 18
      idle();
      if (rd_err1 !== 1'b1) begin errors++; $display("FAIL rr_rd_err18: got %b expected 1", rd_err1); end checks++;
      if (live_cnt1 !== 4'd0) begin errors++; $display("FAIL rr_live18: got %0d expected 0", live_cnt1); end checks++;
   endtask

   initial begin
      test_reset();
      test_expiry();
      test_refresh();
      test_refresh_boundary();
      test_collision();
      test_refresh_unwritten();
      test_reset_midop();
      test_read_restore();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
